// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time image loader.
// Optional trailer checksum is enabled by defining LOADER_CHECKSUM_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package loader_pkg;

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam int LOADER_LANES = 4;
    localparam int CSUM_WIDTH   = 8;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word is the value
// including the byte being accepted, so it is valid while word_done is high.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  lane_q;
    logic [31:0] shift_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else if (accept) begin
            lane_q  <= lane_q + 2'd1;
            shift_q <= word;
        end
    end

    // Bytes enter at the top so the first byte ends up in bits [7:0].
    assign word      = {data, shift_q[31:8]};
    assign word_done = accept && (lane_q == 2'(LOADER_LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header + payload words into RAM, then releases the core.
// Define LOADER_CHECKSUM_EN to require an 8-bit payload-sum trailer byte.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] MAX_WORDS = 32'h80000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    output logic                   byte_ready_o,
    output logic                   ram_ce_o,
    output logic                   ram_we_o,
    output logic [`ADDR_WIDTH-1:0] ram_addr_o,
    output logic [`DATA_WIDTH-1:0] ram_data_o,
    output logic                   core_rst_o,
    output logic                   done_o,
    output logic                   err_o
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = S_CSUM;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t                 state_q, state_d;
    logic [31:0]            len_q;
    logic [31:0]            idx_q;
    logic [`ADDR_WIDTH-1:0] addr_q;
    logic [`DATA_WIDTH-1:0] data_q;
    logic                   ready_q, we_q, done_q, err_q;
    logic                   accept, pack_accept, word_done;
    logic [31:0]            word;
`ifdef LOADER_CHECKSUM_EN
    logic [CSUM_WIDTH-1:0]  sum_q;
`endif

    assign accept      = byte_valid_i && ready_q;
    assign pack_accept = accept && (state_q == S_LEN || state_q == S_DATA);

    byte_packer u_packer (
        .clk       (clk_i),
        .clear     (!rst_i),
        .accept    (pack_accept),
        .data      (byte_i),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (word_done) begin
                    if (word == 32'd0)          state_d = END_STATE;
                    else if (word > MAX_WORDS)  state_d = S_ERR;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA:  if (word_done) state_d = S_WRITE;
            S_WRITE: state_d = (idx_q + 32'd1 == len_q) ? END_STATE : S_DATA;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:  if (accept) state_d = (byte_i == sum_q) ? S_DONE : S_ERR;
`endif
            default: state_d = state_q;
        endcase
    end

    // Status outputs are flopped from the next state so they never glitch.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_LEN;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
            we_q    <= (state_d == S_WRITE);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
            if (state_q == S_LEN && word_done) len_q <= word;
            if (state_q == S_DATA && word_done) begin
                data_q <= `DATA_WIDTH'(word);
                addr_q <= `ADDR_WIDTH'(BASE_ADDR + (idx_q << 2));
            end
            if (state_q == S_WRITE) idx_q <= idx_q + 32'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i)                          sum_q <= '0;
        else if (state_q == S_DATA && accept) sum_q <= sum_q + byte_i;
    end
`endif

    assign byte_ready_o = ready_q;
    assign ram_ce_o     = we_q;
    assign ram_we_o     = we_q;
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = data_q;
    assign core_rst_o   = done_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
